if1_btb_predictor: RTL and testbench
====================================

IF1_BTB_PREDICTOR -- requirements
Module: if1_btb_predictor

Interface
REQ-001 SHALL have parameter ENTRIES, default 64, the number of BTB entries (power of two, 4..1024).
REQ-002 SHALL have parameter RAS_DEPTH, default 8, the number of return-stack entries (power of two, 2..32).
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 pc_in  in  32  IF1 fetch PC.
REQ-007 inst  in  32  ICache instruction word for pc_in.
REQ-008 icache_valid  in  1  fetch request outstanding.
REQ-009 icache_ready  in  1  inst is valid this cycle.
REQ-010 upd_valid  in  1  resolved-branch update from EX.
REQ-011 upd_pc  in  32  resolved branch PC.
REQ-012 upd_taken  in  1  resolved direction.
REQ-013 upd_target  in  32  resolved target.
REQ-014 pred_taken  out  1  predict redirect.
REQ-015 pred_pc  out  32  predicted next PC.
REQ-016 pc_stall  out  1  hold PC register.
REQ-017 if1_id_flush  out  1  insert bubble into IF1/ID.

Function
REQ-018 SHALL compute IW = log2(ENTRIES), index = pc[IW+1:2] and tag = pc[31:IW+2] for both lookup and update.
REQ-019 SHALL store per entry a valid bit, a tag, a 32-bit target and a 2-bit saturating counter.
REQ-020 SHALL assert lookup hit when the entry at index(pc_in) is valid and its tag equals tag(pc_in); lookup is combinational, 0-cycle latency.
REQ-021 SHALL drive pred_taken = icache_ready & hit & counter[1] when no RAS prediction applies.
REQ-022 SHALL drive pred_pc = target when pred_taken, else pc_in + 4 (modulo 2^32).
REQ-023 SHALL, on the clock edge with upd_valid and an update hit: increment the counter (saturating at 3) and write upd_target if upd_taken; otherwise decrement it (saturating at 0).
REQ-024 SHALL, on the clock edge with upd_valid, an update miss and upd_taken: allocate the entry (valid=1, tag, target=upd_target, counter=2'b10); a miss with not-taken SHALL leave the entry unchanged.
REQ-025 SHALL give a same-cycle lookup of an entry being updated the pre-update contents (no forwarding).
REQ-026 SHALL drive pc_stall = if1_id_flush = icache_valid & ~icache_ready, combinationally.
REQ-027 SHALL treat an instruction as accepted only when icache_ready=1; RAS push/pop occurs only on acceptance.

Reset
REQ-028 SHALL, on rst, clear all BTB valid bits, set the RAS pointer and count to 0, and discard any update presented in that cycle.
REQ-029 SHALL drive pred_taken=0 and pred_pc=pc_in+4 while rst is asserted and the cycle after, because BTB and RAS are empty.

Configuration
REQ-030 SHALL compile a return-address stack when macro IF1_RAS_EN is defined.
REQ-031 With IF1_RAS_EN: an accepted BL (inst[31:26]=6'b010101) SHALL push pc_in+4; a full stack SHALL overwrite the oldest entry (circular pointer wrap, count saturates at RAS_DEPTH).
REQ-032 With IF1_RAS_EN: an accepted return (inst[31:26]=6'b010011, rd=0, rj=1, offs16=0) with a non-empty stack SHALL force pred_taken=1 and pred_pc=top, override the BTB, and pop.
REQ-033 With IF1_RAS_EN, a return with an empty stack SHALL fall back to BTB prediction; mispredicts SHALL NOT repair the stack.
REQ-034 Without IF1_RAS_EN: no RAS storage; all predictions come from the BTB only.

Verification
REQ-035 After reset, pc_in=0x1C000000, icache_ready=1 -> pred_taken=0, pred_pc=0x1C000004.
REQ-036 Update pc=0x1C000010 taken, target=0x1C000100, then lookup it -> pred_taken=1, pred_pc=0x1C000100; two not-taken updates -> pred_taken=0.
REQ-037 Two PCs with equal index and different tags (0x1C000010, 0x1C000110 with ENTRIES=64) -> the second allocation replaces the first; the first misses.
REQ-038 icache_valid=1, icache_ready=0 -> pc_stall=1, if1_id_flush=1, pred_taken=0; ready=1 -> both 0.
REQ-039 IF1_RAS_EN: BL at 0x1C000020, then return inst -> pred_taken=1, pred_pc=0x1C000024; RAS_DEPTH+1 BLs then RAS_DEPTH+1 returns -> the last return falls back to the BTB.
REQ-040 Update and lookup of the same index in one cycle -> old prediction this cycle, new prediction next cycle.

Source files
------------

// File: rtl/if1_btb_predictor.sv
// IF1 branch predictor: direct-mapped BTB with 2-bit saturating counters,
// combinational lookup, registered update from EX. Fetch stall/bubble
// generation. Optional return-address stack compiled when IF1_RAS_EN is
// defined; without it all predictions come from the BTB.
module if1_btb_predictor #(
  parameter int ENTRIES   = 64,
  parameter int RAS_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  input  logic [31:0] inst,
  input  logic        icache_valid,
  input  logic        icache_ready,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  output logic        pred_taken,
  output logic [31:0] pred_pc,
  output logic        pc_stall,
  output logic        if1_id_flush
);

  localparam int IW = $clog2(ENTRIES);
  localparam int TW = 30 - IW;

  logic          r_valid  [ENTRIES];
  logic [TW-1:0] r_tag    [ENTRIES];
  logic [31:0]   r_target [ENTRIES];
  logic [1:0]    r_ctr    [ENTRIES];

  logic [IW-1:0] w_idx;
  logic [TW-1:0] w_tag;
  logic          w_hit;
  logic          w_btb_taken;
  logic [31:0]   w_pc_plus4;
  logic [IW-1:0] w_upd_idx;
  logic [TW-1:0] w_upd_tag;
  logic          w_upd_hit;
  logic          w_ras_use;
  logic [31:0]   w_ras_top;
  logic          w_unused;

  assign w_idx       = pc_in[IW+1:2];
  assign w_tag       = pc_in[31:IW+2];
  assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_btb_taken = icache_ready & w_hit & r_ctr[w_idx][1];
  assign w_pc_plus4  = pc_in + 32'd4;

  assign w_upd_idx = upd_pc[IW+1:2];
  assign w_upd_tag = upd_pc[31:IW+2];
  assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);

  assign pc_stall     = icache_valid & ~icache_ready;
  assign if1_id_flush = icache_valid & ~icache_ready;

`ifdef IF1_RAS_EN
  localparam int RW = $clog2(RAS_DEPTH);
  localparam logic [RW:0] RAS_FULL = (RW+1)'(RAS_DEPTH);

  logic [31:0]   r_ras [RAS_DEPTH];
  logic [RW-1:0] r_ras_ptr;
  logic [RW:0]   r_ras_cnt;

  logic          w_is_bl;
  logic          w_is_ret;
  logic [RW-1:0] w_top_ptr;
  logic          w_ras_push;
  logic          w_ras_pop;

  assign w_is_bl    = (inst[31:26] == 6'b010101);
  assign w_is_ret   = (inst[31:26] == 6'b010011) && (inst[25:10] == '0) &&
                      (inst[9:5] == 5'd1) && (inst[4:0] == '0);
  assign w_top_ptr  = r_ras_ptr - 1'b1;
  assign w_ras_top  = r_ras[w_top_ptr];
  assign w_ras_push = icache_ready & w_is_bl;
  assign w_ras_pop  = icache_ready & w_is_ret & (r_ras_cnt != '0);
  assign w_ras_use  = w_ras_pop;
  assign w_unused   = ^{pc_in[1:0], upd_pc[1:0]};

  // Circular return stack: a push when full overwrites the oldest slot,
  // count saturates at depth; mispredicts never repair it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ras_ptr <= '0;
      r_ras_cnt <= '0;
    end else if (w_ras_push) begin
      r_ras[r_ras_ptr] <= w_pc_plus4;
      r_ras_ptr        <= r_ras_ptr + 1'b1;
      if (r_ras_cnt != RAS_FULL) r_ras_cnt <= r_ras_cnt + 1'b1;
    end else if (w_ras_pop) begin
      r_ras_ptr <= w_top_ptr;
      r_ras_cnt <= r_ras_cnt - 1'b1;
    end
  end
`else
  assign w_ras_use = 1'b0;
  assign w_ras_top = '0;
  assign w_unused  = ^{inst, pc_in[1:0], upd_pc[1:0]};
`endif

  // Prediction mux: RAS overrides BTB; nothing is predicted during reset.
  always_comb begin
    pred_taken = 1'b0;
    pred_pc    = w_pc_plus4;
    if (!rst) begin
      if (w_ras_use) begin
        pred_taken = 1'b1;
        pred_pc    = w_ras_top;
      end else if (w_btb_taken) begin
        pred_taken = 1'b1;
        pred_pc    = r_target[w_idx];
      end
    end
  end

  // BTB training: hit adjusts counter (and target when taken), taken miss allocates.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) r_valid[i] <= 1'b0;
    end else if (upd_valid) begin
      if (w_upd_hit) begin
        if (upd_taken) begin
          if (r_ctr[w_upd_idx] != 2'd3) r_ctr[w_upd_idx] <= r_ctr[w_upd_idx] + 2'd1;
          r_target[w_upd_idx] <= upd_target;
        end else begin
          if (r_ctr[w_upd_idx] != 2'd0) r_ctr[w_upd_idx] <= r_ctr[w_upd_idx] - 2'd1;
        end
      end else if (upd_taken) begin
        r_valid[w_upd_idx]  <= 1'b1;
        r_tag[w_upd_idx]    <= w_upd_tag;
        r_target[w_upd_idx] <= upd_target;
        r_ctr[w_upd_idx]    <= 2'b10;
      end
    end
  end

endmodule

// File: tb/tb_if1_btb_predictor.sv
// Self-checking bench for if1_btb_predictor: directed scenarios followed by
// randomized traffic, every cycle compared against a behavioural model.
// Define IF1_RAS_EN for both RTL and bench to exercise the return stack.
module tb_if1_btb_predictor;

  localparam int ENTRIES   = 64;
  localparam int RAS_DEPTH = 8;
  localparam logic [31:0] BL_OP  = 32'h5400_0000;
  localparam logic [31:0] RET_OP = 32'h4C00_0020;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in, inst, upd_pc, upd_target;
  logic        icache_valid, icache_ready, upd_valid, upd_taken;
  logic        pred_taken, pc_stall, if1_id_flush;
  logic [31:0] pred_pc;

  always #5 clk = ~clk;

  if1_btb_predictor #(.ENTRIES(ENTRIES), .RAS_DEPTH(RAS_DEPTH)) u_dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .inst(inst),
    .icache_valid(icache_valid), .icache_ready(icache_ready),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .pred_taken(pred_taken), .pred_pc(pred_pc),
    .pc_stall(pc_stall), .if1_id_flush(if1_id_flush)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: table keyed by word index, counters as plain integers.
  bit          m_valid [ENTRIES];
  logic [31:0] m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];
  logic [31:0] m_ras   [$];

  function automatic int unsigned idx_of(input logic [31:0] pc);
    return (pc / 4) % ENTRIES;
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] pc);
    return pc / (4 * ENTRIES);
  endfunction

  // Checks outputs for the current inputs, then advances model and DUT one edge.
  task automatic step();
    int unsigned i;
    bit          hit, ras_use, exp_taken, exp_stall;
    logic [31:0] exp_pc;
    i       = idx_of(pc_in);
    hit     = m_valid[i] && (m_tag[i] == tag_of(pc_in));
    ras_use = 1'b0;
`ifdef IF1_RAS_EN
    ras_use = icache_ready && (inst == RET_OP) && (m_ras.size() > 0);
`endif
    exp_pc    = pc_in + 32'd4;
    exp_taken = 1'b0;
    if (!rst && ras_use) begin
      exp_taken = 1'b1;
      exp_pc    = m_ras[$];
    end else if (!rst && icache_ready && hit && m_ctr[i] >= 2) begin
      exp_taken = 1'b1;
      exp_pc    = m_tgt[i];
    end
    exp_stall = icache_valid && !icache_ready;
    #3;
    check("pred_taken", pred_taken, exp_taken);
    check("pred_pc", pred_pc, exp_pc);
    check("pc_stall", pc_stall, exp_stall);
    check("if1_id_flush", if1_id_flush, exp_stall);
    @(posedge clk);
    if (rst) begin
      foreach (m_valid[k]) m_valid[k] = 1'b0;
      m_ras.delete();
    end else begin
      if (upd_valid) begin
        i = idx_of(upd_pc);
        if (m_valid[i] && m_tag[i] == tag_of(upd_pc)) begin
          if (upd_taken) begin
            m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
            m_tgt[i] = upd_target;
          end else begin
            m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
          end
        end else if (upd_taken) begin
          m_valid[i] = 1'b1;
          m_tag[i]   = tag_of(upd_pc);
          m_tgt[i]   = upd_target;
          m_ctr[i]   = 2;
        end
      end
`ifdef IF1_RAS_EN
      if (icache_ready && inst[31:26] == 6'b010101) begin
        m_ras.push_back(pc_in + 32'd4);
        if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
      end else if (ras_use) begin
        void'(m_ras.pop_back());
      end
`endif
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic set_upd(input logic v, input logic [31:0] pc, input logic t, input logic [31:0] tgt);
    upd_valid  = v;
    upd_pc     = pc;
    upd_taken  = t;
    upd_target = tgt;
  endtask

  initial begin
    rst = 1'b1; pc_in = 32'h1C00_0000; inst = '0;
    icache_valid = 1'b1; icache_ready = 1'b1;
    set_upd(1'b0, '0, 1'b0, '0);
    @(posedge clk); #1;
    step();
    rst = 1'b0;

    // Out of reset: fall-through prediction.
    #2;
    check("reset_taken", pred_taken, 1'b0);
    check("reset_pc", pred_pc, 32'h1C00_0004);
    step();

    // Train taken, then two not-taken updates.
    set_upd(1'b1, 32'h1C00_0010, 1'b1, 32'h1C00_0100);
    step();
    set_upd(1'b0, '0, 1'b0, '0);
    pc_in = 32'h1C00_0010;
    #2;
    check("train_taken", pred_taken, 1'b1);
    check("train_pc", pred_pc, 32'h1C00_0100);
    step();
    set_upd(1'b1, 32'h1C00_0010, 1'b0, '0);
    step();
    step();
    set_upd(1'b0, '0, 1'b0, '0);
    #2;
    check("nt_taken", pred_taken, 1'b0);
    check("nt_pc", pred_pc, 32'h1C00_0014);
    step();

    // Index aliasing: second allocation evicts the first.
    do_reset();
    set_upd(1'b1, 32'h1C00_0010, 1'b1, 32'h1C00_0100);
    step();
    set_upd(1'b1, 32'h1C00_0110, 1'b1, 32'h1C00_0200);
    step();
    set_upd(1'b0, '0, 1'b0, '0);
    pc_in = 32'h1C00_0110;
    #2;
    check("alias_new_taken", pred_taken, 1'b1);
    check("alias_new_pc", pred_pc, 32'h1C00_0200);
    step();
    pc_in = 32'h1C00_0010;
    #2;
    check("alias_old_taken", pred_taken, 1'b0);
    check("alias_old_pc", pred_pc, 32'h1C00_0014);
    step();

    // Stall while the ICache has not delivered.
    pc_in = 32'h1C00_0110; icache_ready = 1'b0;
    #2;
    check("stall", pc_stall, 1'b1);
    check("flush", if1_id_flush, 1'b1);
    check("stall_taken", pred_taken, 1'b0);
    step();
    icache_ready = 1'b1;
    #2;
    check("nostall", pc_stall, 1'b0);
    check("noflush", if1_id_flush, 1'b0);
    step();

    // Same-cycle update and lookup: old prediction now, new one next cycle.
    set_upd(1'b1, 32'h1C00_0110, 1'b0, '0);
    #2;
    check("fwd_old", pred_taken, 1'b1);
    step();
    set_upd(1'b0, '0, 1'b0, '0);
    #2;
    check("fwd_new", pred_taken, 1'b0);
    step();

`ifdef IF1_RAS_EN
    do_reset();
    pc_in = 32'h1C00_0020; inst = BL_OP;
    step();
    pc_in = 32'h1C00_0080; inst = RET_OP;
    #2;
    check("ras_taken", pred_taken, 1'b1);
    check("ras_pc", pred_pc, 32'h1C00_0024);
    step();
    set_upd(1'b1, 32'h1C00_2000, 1'b1, 32'h1C00_3000);
    inst = '0;
    step();
    set_upd(1'b0, '0, 1'b0, '0);
    for (int k = 0; k <= RAS_DEPTH; k++) begin
      pc_in = 32'h1C00_1000 + 32'(8 * k); inst = BL_OP;
      step();
    end
    for (int k = 0; k <= RAS_DEPTH; k++) begin
      pc_in = 32'h1C00_2000; inst = RET_OP;
      #2;
      check("ras_deep_taken", pred_taken, 1'b1);
      if (k < RAS_DEPTH)
        check("ras_deep_pc", pred_pc, 32'h1C00_1004 + 32'(8 * (RAS_DEPTH - k)));
      else
        check("ras_empty_btb_pc", pred_pc, 32'h1C00_3000);
      step();
    end
    inst = '0;
`endif

    // Randomized traffic over a small PC window so entries hit and alias.
    for (int n = 0; n < 3000; n++) begin
      int unsigned sel;
      rst          = ($urandom_range(0, 99) == 0);
      pc_in        = 32'h1C00_0000 + ($urandom_range(0, 255) << 2);
      icache_valid = $urandom_range(0, 1);
      icache_ready = ($urandom_range(0, 3) != 0);
      sel          = $urandom_range(0, 3);
      inst         = (sel == 0) ? (BL_OP | ($urandom & 32'h03FF_FFFF)) :
                     (sel == 1) ? RET_OP : $urandom;
      set_upd($urandom_range(0, 1), 32'h1C00_0000 + ($urandom_range(0, 255) << 2),
              $urandom_range(0, 1), $urandom & 32'hFFFF_FFFC);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
